ctrl_pipe_unit: RTL and testbench

CTRL_PIPE_UNIT -- requirements
Module: ctrl_pipe_unit

---
 rtl/ctrl_pkg.sv | 66 ++++++
 rtl/ctrl_pipe_unit_decode.sv | 88 ++++++++
 rtl/ctrl_pipe_unit.sv | 120 ++++++++++++
 tb/tb_ctrl_pipe_unit.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared constants for the control pipeline.
//   - opcode and R-type funct encodings recognised by the decoder
//   - alu_mid and out_select code points
//   - bit positions of every field inside the ex/mem/wb control buses
package ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_NOOP  = 6'h00;
  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_AND   = 3'b010;
  localparam logic [2:0] ALU_OR    = 3'b011;
  localparam logic [2:0] ALU_XOR   = 3'b100;
  localparam logic [2:0] ALU_SLT   = 3'b101;
  localparam logic [2:0] ALU_RTYPE = 3'b111;

  localparam logic [1:0] OUT_ALU  = 2'b00;
  localparam logic [1:0] OUT_LUI  = 2'b01;
  localparam logic [1:0] OUT_MULT = 2'b10;
  localparam logic [1:0] OUT_HILO = 2'b11;

  localparam int EX_W  = 11;
  localparam int MEM_W = 2;
  localparam int WB_W  = 4;

  // ex_ctrl = {alusrc_a, reg_dst, alu_mid[2:0], se_ze, beq, bne, jump, start_mult, mult_sign}
  localparam int EX_ALUSRC_A   = 10;
  localparam int EX_REG_DST    = 9;
  localparam int EX_ALU_MID_HI = 8;
  localparam int EX_ALU_MID_LO = 6;
  localparam int EX_SE_ZE      = 5;
  localparam int EX_BEQ        = 4;
  localparam int EX_BNE        = 3;
  localparam int EX_JUMP       = 2;
  localparam int EX_START_MULT = 1;
  localparam int EX_MULT_SIGN  = 0;

  // mem_ctrl = {mem_write, mem_read}
  localparam int MEM_WRITE = 1;
  localparam int MEM_READ  = 0;

  // wb_ctrl = {reg_write, mem_to_reg, out_select[1:0]}
  localparam int WB_REG_WRITE  = 3;
  localparam int WB_MEM_TO_REG = 2;
  localparam int WB_OUT_SEL_HI = 1;
  localparam int WB_OUT_SEL_LO = 0;

endpackage

// File: rtl/ctrl_pipe_unit_decode.sv
// ctrl_decode: purely combinational instruction decoder.
//   op_code, funct -> ex_ctrl, mem_ctrl, wb_ctrl control fields
//   legal          -> opcode is one the pipeline knows
//   uses_hilo      -> MFHI/MFLO/MULT/MULTU (subject to the multiply hazard)
// Fields not set by an instruction stay 0; unknown opcodes decode to all zeros.
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [5:0]       op_code,
  input  logic [5:0]       funct,
  output logic [EX_W-1:0]  ex_ctrl,
  output logic [MEM_W-1:0] mem_ctrl,
  output logic [WB_W-1:0]  wb_ctrl,
  output logic             legal,
  output logic             uses_hilo
);

  always_comb begin
    ex_ctrl   = '0;
    mem_ctrl  = '0;
    wb_ctrl   = '0;
    legal     = 1'b1;
    uses_hilo = 1'b0;
    case (op_code)
      OP_RTYPE: begin
        // every funct is accepted; unlisted ones are generic ALU R-types
        case (funct)
          FN_NOOP: begin
          end
          FN_MFHI, FN_MFLO: begin
            wb_ctrl[WB_REG_WRITE]                 = 1'b1;
            ex_ctrl[EX_REG_DST]                   = 1'b1;
            wb_ctrl[WB_OUT_SEL_HI:WB_OUT_SEL_LO]  = OUT_HILO;
            uses_hilo                             = 1'b1;
          end
          FN_MULT, FN_MULTU: begin
            ex_ctrl[EX_START_MULT]                = 1'b1;
            ex_ctrl[EX_MULT_SIGN]                 = (funct == FN_MULT);
            wb_ctrl[WB_OUT_SEL_HI:WB_OUT_SEL_LO]  = OUT_MULT;
            uses_hilo                             = 1'b1;
          end
          default: begin
            wb_ctrl[WB_REG_WRITE]                 = 1'b1;
            ex_ctrl[EX_REG_DST]                   = 1'b1;
            ex_ctrl[EX_ALU_MID_HI:EX_ALU_MID_LO]  = ALU_RTYPE;
          end
        endcase
      end
      OP_J:   ex_ctrl[EX_JUMP] = 1'b1;
      OP_BEQ: ex_ctrl[EX_BEQ]  = 1'b1;
      OP_BNE: ex_ctrl[EX_BNE]  = 1'b1;
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU: begin
        wb_ctrl[WB_REG_WRITE] = 1'b1;
        ex_ctrl[EX_ALUSRC_A]  = 1'b1;
        ex_ctrl[EX_SE_ZE]     = 1'b1;
        if (op_code == OP_SLTI || op_code == OP_SLTIU)
          ex_ctrl[EX_ALU_MID_HI:EX_ALU_MID_LO] = ALU_SLT;
      end
      OP_ANDI, OP_ORI, OP_XORI: begin
        wb_ctrl[WB_REG_WRITE] = 1'b1;
        ex_ctrl[EX_ALUSRC_A]  = 1'b1;
        case (op_code)
          OP_ANDI: ex_ctrl[EX_ALU_MID_HI:EX_ALU_MID_LO] = ALU_AND;
          OP_ORI:  ex_ctrl[EX_ALU_MID_HI:EX_ALU_MID_LO] = ALU_OR;
          default: ex_ctrl[EX_ALU_MID_HI:EX_ALU_MID_LO] = ALU_XOR;
        endcase
      end
      OP_LUI: begin
        wb_ctrl[WB_REG_WRITE]                = 1'b1;
        wb_ctrl[WB_OUT_SEL_HI:WB_OUT_SEL_LO] = OUT_LUI;
      end
      OP_LW: begin
        wb_ctrl[WB_REG_WRITE]  = 1'b1;
        wb_ctrl[WB_MEM_TO_REG] = 1'b1;
        ex_ctrl[EX_ALUSRC_A]   = 1'b1;
        ex_ctrl[EX_SE_ZE]      = 1'b1;
        mem_ctrl[MEM_READ]     = 1'b1;
      end
      OP_SW: begin
        ex_ctrl[EX_ALUSRC_A] = 1'b1;
        ex_ctrl[EX_SE_ZE]    = 1'b1;
        mem_ctrl[MEM_WRITE]  = 1'b1;
      end
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/ctrl_pipe_unit.sv
// ctrl_pipe_unit: control pipeline ID -> EX -> MEM -> WB with multiply hazard.
//   clk, rst_n              clock, synchronous active-low reset
//   id_valid/op_code/funct  instruction in ID
//   stall_in, flush         external data-hazard stall, taken-branch kill
//   id_stall, illegal_op    ID-stage status (combinational)
//   ex_*/mem_*/wb_*         registered control per stage
//   mult_busy               HI/LO unit busy (counter nonzero)
module ctrl_pipe_unit
  import ctrl_pkg::*;
#(
  parameter int MULT_LATENCY = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [5:0]       op_code,
  input  logic [5:0]       funct,
  input  logic             stall_in,
  input  logic             flush,
  output logic             id_stall,
  output logic             illegal_op,
  output logic             ex_valid,
  output logic [EX_W-1:0]  ex_ctrl,
  output logic             mem_valid,
  output logic [MEM_W-1:0] mem_ctrl,
  output logic             wb_valid,
  output logic [WB_W-1:0]  wb_ctrl,
  output logic             mult_busy
);

  localparam int CNT_W = $clog2(MULT_LATENCY + 1);

  logic [EX_W-1:0]  dec_ex;
  logic [MEM_W-1:0] dec_mem;
  logic [WB_W-1:0]  dec_wb;
  logic             dec_legal;
  logic             dec_hilo;
  logic             issue;

  // ID/EX carries the later-stage fields forward alongside ex_ctrl
  logic             ex_valid_q,  ex_valid_d;
  logic [EX_W-1:0]  ex_ctrl_q,   ex_ctrl_d;
  logic [MEM_W-1:0] ex_mem_q,    ex_mem_d;
  logic [WB_W-1:0]  ex_wb_q,     ex_wb_d;
  logic             mem_valid_q, mem_valid_d;
  logic [MEM_W-1:0] mem_ctrl_q,  mem_ctrl_d;
  logic [WB_W-1:0]  mem_wb_q,    mem_wb_d;
  logic             wb_valid_q,  wb_valid_d;
  logic [WB_W-1:0]  wb_ctrl_q,   wb_ctrl_d;
  logic [CNT_W-1:0] cnt_q,       cnt_d;

  ctrl_decode u_decode (
    .op_code   (op_code),
    .funct     (funct),
    .ex_ctrl   (dec_ex),
    .mem_ctrl  (dec_mem),
    .wb_ctrl   (dec_wb),
    .legal     (dec_legal),
    .uses_hilo (dec_hilo)
  );

  always_comb begin
    mult_busy  = (cnt_q != '0);
    id_stall   = stall_in | (id_valid & dec_hilo & mult_busy);
    illegal_op = id_valid & ~dec_legal;
    issue      = id_valid & ~id_stall & ~flush & dec_legal;

    ex_valid_d  = issue;
    ex_ctrl_d   = issue ? dec_ex  : '0;
    ex_mem_d    = issue ? dec_mem : '0;
    ex_wb_d     = issue ? dec_wb  : '0;

    // downstream stages never freeze
    mem_valid_d = ex_valid_q;
    mem_ctrl_d  = ex_mem_q;
    mem_wb_d    = ex_wb_q;
    wb_valid_d  = mem_valid_q;
    wb_ctrl_d   = mem_wb_q;

    cnt_d = cnt_q;
    if (issue && dec_ex[EX_START_MULT])
      cnt_d = CNT_W'(MULT_LATENCY);
    else if (cnt_q != '0)
      cnt_d = cnt_q - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_valid_q  <= 1'b0;
      ex_ctrl_q   <= '0;
      ex_mem_q    <= '0;
      ex_wb_q     <= '0;
      mem_valid_q <= 1'b0;
      mem_ctrl_q  <= '0;
      mem_wb_q    <= '0;
      wb_valid_q  <= 1'b0;
      wb_ctrl_q   <= '0;
      cnt_q       <= '0;
    end else begin
      ex_valid_q  <= ex_valid_d;
      ex_ctrl_q   <= ex_ctrl_d;
      ex_mem_q    <= ex_mem_d;
      ex_wb_q     <= ex_wb_d;
      mem_valid_q <= mem_valid_d;
      mem_ctrl_q  <= mem_ctrl_d;
      mem_wb_q    <= mem_wb_d;
      wb_valid_q  <= wb_valid_d;
      wb_ctrl_q   <= wb_ctrl_d;
      cnt_q       <= cnt_d;
    end
  end

  assign ex_valid  = ex_valid_q;
  assign ex_ctrl   = ex_ctrl_q;
  assign mem_valid = mem_valid_q;
  assign mem_ctrl  = mem_ctrl_q;
  assign wb_valid  = wb_valid_q;
  assign wb_ctrl   = wb_ctrl_q;

endmodule

// File: tb/tb_ctrl_pipe_unit.sv
// tb_ctrl_pipe_unit: directed and randomized checks of ctrl_pipe_unit
// against a history-based reference model (MULT_LATENCY = 4).
module tb_ctrl_pipe_unit;

  localparam int L = 4;

  logic        clk = 1'b0;
  logic        rst_n, id_valid, stall_in, flush;
  logic [5:0]  op_code, funct;
  logic        id_stall, illegal_op, ex_valid, mem_valid, wb_valid, mult_busy;
  logic [10:0] ex_ctrl;
  logic [1:0]  mem_ctrl;
  logic [3:0]  wb_ctrl;

  ctrl_pipe_unit #(.MULT_LATENCY(L)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .op_code(op_code),
    .funct(funct), .stall_in(stall_in), .flush(flush), .id_stall(id_stall),
    .illegal_op(illegal_op), .ex_valid(ex_valid), .ex_ctrl(ex_ctrl),
    .mem_valid(mem_valid), .mem_ctrl(mem_ctrl), .wb_valid(wb_valid),
    .wb_ctrl(wb_ctrl), .mult_busy(mult_busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       valid;
    logic       alusrc_a, reg_dst;
    logic [2:0] alu_mid;
    logic       se_ze, beq, bne, jump, start_mult, mult_sign;
    logic       mem_write, mem_read;
    logic       reg_write, mem_to_reg;
    logic [1:0] out_sel;
  } rec_t;

  rec_t hist[$];     // instructions that entered EX, oldest first
  int   cyc;         // cycle number of the current ID cycle
  int   mult_ex;     // cycle in which the last MULT/MULTU was in EX
  int   n_cmp = 0;
  int   n_mis = 0;

  logic [5:0] ops [18] = '{6'h00, 6'h00, 6'h00, 6'h02, 6'h04, 6'h05, 6'h08, 6'h09,
                           6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B,
                           6'h3F, 6'h11};
  logic [5:0] fns [6]  = '{6'h00, 6'h10, 6'h12, 6'h18, 6'h19, 6'h20};

  function automatic rec_t ref_decode(input logic [5:0] op, input logic [5:0] fn,
                                      output bit legal, output bit hilo);
    rec_t r = '0;
    legal = 1'b1;
    hilo  = 1'b0;
    case (op)
      6'h00: begin
        if (fn == 6'h10 || fn == 6'h12) begin
          r.reg_write = 1; r.reg_dst = 1; r.out_sel = 2'b11; hilo = 1;
        end else if (fn == 6'h18 || fn == 6'h19) begin
          r.start_mult = 1; r.mult_sign = (fn == 6'h18); r.out_sel = 2'b10; hilo = 1;
        end else if (fn != 6'h00) begin
          r.reg_write = 1; r.reg_dst = 1; r.alu_mid = 3'b111;
        end
      end
      6'h02: r.jump = 1;
      6'h04: r.beq = 1;
      6'h05: r.bne = 1;
      6'h08, 6'h09: begin r.reg_write = 1; r.alusrc_a = 1; r.se_ze = 1; end
      6'h0A, 6'h0B: begin r.reg_write = 1; r.alusrc_a = 1; r.se_ze = 1; r.alu_mid = 3'b101; end
      6'h0C: begin r.reg_write = 1; r.alusrc_a = 1; r.alu_mid = 3'b010; end
      6'h0D: begin r.reg_write = 1; r.alusrc_a = 1; r.alu_mid = 3'b011; end
      6'h0E: begin r.reg_write = 1; r.alusrc_a = 1; r.alu_mid = 3'b100; end
      6'h0F: begin r.reg_write = 1; r.out_sel = 2'b01; end
      6'h23: begin r.reg_write = 1; r.alusrc_a = 1; r.se_ze = 1; r.mem_to_reg = 1; r.mem_read = 1; end
      6'h2B: begin r.alusrc_a = 1; r.se_ze = 1; r.mem_write = 1; end
      default: legal = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic [10:0] pk_ex(input rec_t r);
    return {r.alusrc_a, r.reg_dst, r.alu_mid, r.se_ze, r.beq, r.bne, r.jump,
            r.start_mult, r.mult_sign};
  endfunction
  function automatic logic [1:0] pk_mem(input rec_t r);
    return {r.mem_write, r.mem_read};
  endfunction
  function automatic logic [3:0] pk_wb(input rec_t r);
    return {r.reg_write, r.mem_to_reg, r.out_sel};
  endfunction

  // One ID cycle: drive inputs, compare everything with the model, clock.
  task automatic step(input logic v, input logic [5:0] op, input logic [5:0] fn,
                      input logic st, input logic fl, input logic rs,
                      output logic stall_seen);
    rec_t d, e, m, w;
    bit   legal, hilo, busy;
    logic exp_stall, exp_ill;
    int   age;
    id_valid = v; op_code = op; funct = fn; stall_in = st; flush = fl; rst_n = rs;
    #3;
    d = ref_decode(op, fn, legal, hilo);
    age = cyc - mult_ex;
    busy = (age >= 0) && (age < L);
    exp_stall = st | (v & hilo & busy);
    exp_ill   = v & !legal;
    e = hist[hist.size()-1];
    m = hist[hist.size()-2];
    w = hist[hist.size()-3];
    n_cmp++; if (id_stall !== exp_stall) begin n_mis++;
      $display("FAIL id_stall cyc=%0d got=%b exp=%b", cyc, id_stall, exp_stall); end
    n_cmp++; if (illegal_op !== exp_ill) begin n_mis++;
      $display("FAIL illegal_op cyc=%0d got=%b exp=%b", cyc, illegal_op, exp_ill); end
    n_cmp++; if (mult_busy !== busy) begin n_mis++;
      $display("FAIL mult_busy cyc=%0d got=%b exp=%b", cyc, mult_busy, busy); end
    n_cmp++; if ({ex_valid, ex_ctrl} !== {e.valid, pk_ex(e)}) begin n_mis++;
      $display("FAIL ex_stage cyc=%0d got=%b/%h exp=%b/%h", cyc, ex_valid, ex_ctrl, e.valid, pk_ex(e)); end
    n_cmp++; if ({mem_valid, mem_ctrl} !== {m.valid, pk_mem(m)}) begin n_mis++;
      $display("FAIL mem_stage cyc=%0d got=%b/%b exp=%b/%b", cyc, mem_valid, mem_ctrl, m.valid, pk_mem(m)); end
    n_cmp++; if ({wb_valid, wb_ctrl} !== {w.valid, pk_wb(w)}) begin n_mis++;
      $display("FAIL wb_stage cyc=%0d got=%b/%b exp=%b/%b", cyc, wb_valid, wb_ctrl, w.valid, pk_wb(w)); end
    stall_seen = id_stall;
    @(posedge clk); #1;
    if (!rs) begin
      repeat (3) hist.push_back('0);
      mult_ex = -1000;
    end else if (v && !exp_stall && !fl && legal) begin
      d.valid = 1'b1;
      hist.push_back(d);
      if (d.start_mult) mult_ex = cyc + 1;
    end else begin
      hist.push_back('0);
    end
    while (hist.size() > 4) void'(hist.pop_front());
    cyc++;
  endtask

  task automatic idle(input int n);
    logic s;
    repeat (n) step(1'b0, 6'h00, 6'h00, 1'b0, 1'b0, 1'b1, s);
  endtask

  task automatic test_reset;
    id_valid = 0; op_code = 0; funct = 0; stall_in = 0; flush = 0; rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    hist.delete();
    repeat (3) hist.push_back('0);
    mult_ex = -1000;
    cyc = 0;
    n_cmp++; if ({ex_valid, mem_valid, wb_valid} !== 3'b000) begin n_mis++;
      $display("FAIL reset_valids got=%b exp=000", {ex_valid, mem_valid, wb_valid}); end
    n_cmp++; if ({ex_ctrl, mem_ctrl, wb_ctrl} !== 17'h0) begin n_mis++;
      $display("FAIL reset_ctrl got=%h exp=0", {ex_ctrl, mem_ctrl, wb_ctrl}); end
    n_cmp++; if (mult_busy !== 1'b0) begin n_mis++;
      $display("FAIL reset_busy got=%b exp=0", mult_busy); end
    stall_in = 1; #1;
    n_cmp++; if (id_stall !== 1'b1) begin n_mis++;
      $display("FAIL reset_stall_follows got=%b exp=1", id_stall); end
    stall_in = 0;
  endtask

  task automatic test_addi;
    logic s;
    step(1'b1, 6'h08, 6'($urandom), 1'b0, 1'b0, 1'b1, s);
    n_cmp++; if ({ex_valid, ex_ctrl} !== {1'b1, 11'b1_0_000_1_00000}) begin n_mis++;
      $display("FAIL addi_ex got=%b/%b exp=1/10000100000", ex_valid, ex_ctrl); end
    idle(2);
    n_cmp++; if ({wb_valid, wb_ctrl} !== 5'b1_1000) begin n_mis++;
      $display("FAIL addi_wb got=%b/%b exp=1/1000", wb_valid, wb_ctrl); end
  endtask

  task automatic test_lw_sw;
    logic s;
    step(1'b1, 6'h23, 6'h00, 1'b0, 1'b0, 1'b1, s);
    step(1'b1, 6'h2B, 6'h00, 1'b0, 1'b0, 1'b1, s);
    n_cmp++; if (mem_ctrl !== 2'b01) begin n_mis++;
      $display("FAIL lw_mem got=%b exp=01", mem_ctrl); end
    idle(1);
    n_cmp++; if (mem_ctrl !== 2'b10) begin n_mis++;
      $display("FAIL sw_mem got=%b exp=10", mem_ctrl); end
    n_cmp++; if (wb_ctrl[2] !== 1'b1) begin n_mis++;
      $display("FAIL lw_mem_to_reg got=%b exp=1", wb_ctrl[2]); end
    idle(1);
    n_cmp++; if (wb_ctrl[2] !== 1'b0) begin n_mis++;
      $display("FAIL sw_mem_to_reg got=%b exp=0", wb_ctrl[2]); end
  endtask

  // Issue MULT, then hold 'second' instruction in ID and count stall cycles.
  task automatic test_mult_hazard(input logic [5:0] second_fn, input logic [10:0] exp_ex);
    logic s;
    int   stalls = 0;
    idle(L + 1);
    step(1'b1, 6'h00, 6'h18, 1'b0, 1'b0, 1'b1, s);
    n_cmp++; if (s !== 1'b0) begin n_mis++;
      $display("FAIL mult_first_stall got=%b exp=0", s); end
    for (int k = 0; k < 20; k++) begin
      step(1'b1, 6'h00, second_fn, 1'b0, 1'b0, 1'b1, s);
      if (!s) break;
      stalls++;
    end
    n_cmp++; if (stalls !== L) begin n_mis++;
      $display("FAIL hazard_stalls fn=%h got=%0d exp=%0d", second_fn, stalls, L); end
    n_cmp++; if ({ex_valid, ex_ctrl} !== {1'b1, exp_ex}) begin n_mis++;
      $display("FAIL hazard_issue fn=%h got=%b/%b exp=1/%b", second_fn, ex_valid, ex_ctrl, exp_ex); end
  endtask

  task automatic test_illegal_flush;
    logic s;
    step(1'b1, 6'h3F, 6'h00, 1'b0, 1'b0, 1'b1, s);
    n_cmp++; if (ex_valid !== 1'b0) begin n_mis++;
      $display("FAIL illegal_bubble got=%b exp=0", ex_valid); end
    step(1'b1, 6'h04, 6'h00, 1'b0, 1'b1, 1'b1, s);
    n_cmp++; if (ex_valid !== 1'b0) begin n_mis++;
      $display("FAIL flush_bubble got=%b exp=0", ex_valid); end
    step(1'b1, 6'h04, 6'h00, 1'b1, 1'b1, 1'b1, s);
    n_cmp++; if ({s, ex_valid} !== 2'b10) begin n_mis++;
      $display("FAIL flush_stall got=%b exp=10", {s, ex_valid}); end
  endtask

  task automatic test_reset_mult;
    logic s;
    idle(L + 1);
    step(1'b1, 6'h00, 6'h19, 1'b0, 1'b0, 1'b1, s);
    idle(2);
    step(1'b0, 6'h00, 6'h00, 1'b0, 1'b0, 1'b0, s);
    n_cmp++; if ({mult_busy, ex_valid, mem_valid, wb_valid} !== 4'b0000) begin n_mis++;
      $display("FAIL reset_mult got=%b exp=0000", {mult_busy, ex_valid, mem_valid, wb_valid}); end
    step(1'b1, 6'h00, 6'h10, 1'b0, 1'b0, 1'b1, s);
    n_cmp++; if ({s, ex_valid} !== 2'b01) begin n_mis++;
      $display("FAIL mfhi_after_reset got=%b exp=01", {s, ex_valid}); end
  endtask

  task automatic test_random(input int n);
    logic s;
    logic [5:0] op, fn;
    for (int i = 0; i < n; i++) begin
      op = ops[$urandom_range(0, 17)];
      fn = ($urandom_range(0, 3) == 0) ? 6'($urandom) : fns[$urandom_range(0, 5)];
      if (op == 6'h11) op = 6'($urandom);
      step($urandom_range(0, 4) != 0, op, fn, $urandom_range(0, 9) == 0,
           $urandom_range(0, 9) == 0, $urandom_range(0, 59) != 0, s);
    end
  endtask

  initial begin
    test_reset();
    idle(3);
    test_addi();
    test_lw_sw();
    test_mult_hazard(6'h12, 11'b0_1_000_0_00000);  // MULT then MFLO
    test_mult_hazard(6'h18, 11'b0_0_000_0_00011);  // back-to-back MULT
    test_illegal_flush();
    test_reset_mult();
    test_random(600);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

endmodule
